// File: rtl/sram_mem_ctrl.sv
// MEM-stage data-memory controller: splits each 32-bit load/store into two
// 16-bit accesses on an external asynchronous SRAM and stalls the pipeline
// (ready low) while the access is in flight.
module sram_mem_ctrl #(
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned SRAM_DW     = 16,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned MEM_BASE    = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [SRAM_DW-1:0] sram_dq,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOW  = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]         state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic               op_wr, op_wr_nxt;
    logic [SRAM_AW-1:0] hw, hw_nxt;
    logic [31:0]        wdata, wdata_nxt;
    logic [31:0]        rdata, rdata_nxt;
    logic [31:0]        read_data_nxt;
    logic [SRAM_AW-1:0] sram_addr_nxt;
    logic               we_n_nxt, oe_n_nxt;
    logic               dq_oe, dq_oe_nxt;
    logic [SRAM_DW-1:0] dq_out, dq_out_nxt;
    logic [SRAM_AW-1:0] hw_calc;
    logic               phase_end;

    // Even halfword index of the word at (address - MEM_BASE); byte lanes ignored.
    assign hw_calc   = SRAM_AW'((address - 32'(MEM_BASE)) >> 1) & ~SRAM_AW'(1);
    assign phase_end = (cnt == CW'(WAIT_CYCLES));

    // Pipeline handshake: low from the cycle a request appears until DONE.
    assign ready = ((state == IDLE) && !rd_en && !wr_en) || (state == DONE);

    // Bus is driven only while a write phase is active.
    assign sram_dq = dq_oe ? dq_out : {SRAM_DW{1'bz}};

    // Next-state, datapath and next-cycle SRAM strobe decode.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        op_wr_nxt     = op_wr;
        hw_nxt        = hw;
        wdata_nxt     = wdata;
        rdata_nxt     = rdata;
        read_data_nxt = read_data;
        sram_addr_nxt = sram_addr;
        we_n_nxt      = 1'b1;
        oe_n_nxt      = 1'b1;
        dq_oe_nxt     = 1'b0;
        dq_out_nxt    = dq_out;

        case (state)
            IDLE: begin
                if (rd_en || wr_en) begin
                    op_wr_nxt = wr_en;
                    hw_nxt    = hw_calc;
                    wdata_nxt = write_data;
                    cnt_nxt   = '0;
                    state_nxt = LOW;
                end
            end
            LOW: begin
                if (phase_end) begin
                    cnt_nxt   = '0;
                    state_nxt = HIGH;
                    if (!op_wr) rdata_nxt[15:0] = 16'(sram_dq);
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            HIGH: begin
                if (phase_end) begin
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                    if (!op_wr) rdata_nxt[31:16] = 16'(sram_dq);
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                if (!op_wr) read_data_nxt = rdata;
                state_nxt = IDLE;
            end
        endcase

        if (state_nxt == LOW || state_nxt == HIGH) begin
            sram_addr_nxt = (state_nxt == LOW) ? hw_nxt : hw_nxt + SRAM_AW'(1);
            if (op_wr_nxt) begin
                we_n_nxt   = 1'b0;
                dq_oe_nxt  = 1'b1;
                dq_out_nxt = (state_nxt == LOW) ? SRAM_DW'(wdata_nxt[15:0])
                                                : SRAM_DW'(wdata_nxt[31:16]);
            end else begin
                oe_n_nxt = 1'b1 & 1'b0;
            end
        end
    end

    // State and registered outputs; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            op_wr     <= 1'b0;
            hw        <= '0;
            wdata     <= '0;
            rdata     <= '0;
            read_data <= '0;
            sram_addr <= '0;
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            op_wr     <= op_wr_nxt;
            hw        <= hw_nxt;
            wdata     <= wdata_nxt;
            rdata     <= rdata_nxt;
            read_data <= read_data_nxt;
            sram_addr <= sram_addr_nxt;
            sram_we_n <= we_n_nxt;
            sram_oe_n <= oe_n_nxt;
            dq_oe     <= dq_oe_nxt;
            dq_out    <= dq_out_nxt;
        end
    end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Scoreboard bench for sram_mem_ctrl with a behavioural asynchronous SRAM.
module tb_sram_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en, wr_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_we_n, sram_oe_n;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic        we;
        logic [17:0] addr;
        logic [15:0] data;
    } bus_ev_t;

    typedef struct packed {
        logic [31:0] rd;
        logic [7:0]  lat;
    } done_ev_t;

    bus_ev_t  bus_q[$];
    done_ev_t done_q[$];

    logic [15:0] mem [0:63];
    logic        mon_en = 1'b1;

    always #5 clk = ~clk;

    sram_mem_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq    (sram_dq),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n)
    );

    // Behavioural SRAM: drives only when read-enabled, writes on each we_n-low cycle.
    assign sram_dq = (!sram_oe_n && sram_we_n) ? mem[sram_addr[5:0]] : 16'hzzzz;
    always @(posedge clk) if (!sram_we_n) mem[sram_addr[5:0]] <= sram_dq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    // Monitor: pops expected bus events and completions as the DUT presents them.
    int       lat  = 0;
    bit       busy = 0;
    bit       pend = 0;
    done_ev_t cur;
    bus_ev_t  ev;

    always @(negedge clk) begin
        if (!mon_en) begin
            busy = 0; lat = 0; pend = 0;
        end else begin
            if (pend) begin
                chk("read_data", read_data, cur.rd);
                pend = 0;
            end
            if (!sram_we_n || !sram_oe_n) begin
                chk("strobe_excl", 32'(!sram_we_n && !sram_oe_n), 32'd0);
                if (bus_q.size() == 0) begin
                    chk("unexpected_bus_cycle", 32'(sram_addr), 32'hFFFF_FFFF);
                end else begin
                    ev = bus_q.pop_front();
                    chk("bus_we", 32'(!sram_we_n), 32'(ev.we));
                    chk("bus_addr", 32'(sram_addr), 32'(ev.addr));
                    if (ev.we) chk("bus_wdata", 32'(sram_dq), 32'(ev.data));
                    else       chk("bus_rdata_nocontention", 32'(sram_dq), 32'(mem[sram_addr[5:0]]));
                end
            end
            if (!ready) begin
                busy = 1;
                lat++;
            end else if (busy) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    cur = done_q.pop_front();
                    chk("latency", 32'(lat), 32'(cur.lat));
                    pend = 1;
                end
                busy = 0;
                lat  = 0;
            end
        end
    end

    // Issue one request, queue its expected bus cycles and result, hold until ready.
    task automatic access(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input logic [17:0] hw,
                          input logic [15:0] lo, input logic [15:0] hi,
                          input logic [31:0] exp_rd);
        bit got;
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 2; c++)
                bus_q.push_back('{w, hw + 18'(p), (p == 0) ? lo : hi});
        done_q.push_back('{exp_rd, 8'd5});
        @(posedge clk); #1;
        wr_en = w; rd_en = r; address = a; write_data = d;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready) begin got = 1; break; end
        end
        chk("done_timeout", 32'(got), 32'd1);
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        address = 32'd0; write_data = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ready", 32'(ready), 32'd1);
            chk("idle_strobes", {30'd0, sram_we_n, sram_oe_n}, 32'd3);
            chk("idle_dq_z", 32'(sram_dq === 16'hzzzz), 32'd1);
        end

        access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 18'd0, 16'hBEEF, 16'hDEAD, 32'h0);
        access(1'b0, 1'b1, 32'd1024, 32'h0,        18'd0, 16'h0,    16'h0,    32'hDEADBEEF);
        access(1'b1, 1'b0, 32'd1028, 32'h12345678, 18'd2, 16'h5678, 16'h1234, 32'hDEADBEEF);
        access(1'b0, 1'b1, 32'd1028, 32'h0,        18'd2, 16'h0,    16'h0,    32'h12345678);
        access(1'b0, 1'b1, 32'd1024, 32'h0,        18'd0, 16'h0,    16'h0,    32'hDEADBEEF);
        access(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, 18'd4, 16'h5A5A, 16'hA5A5, 32'hDEADBEEF);
        access(1'b0, 1'b1, 32'd1032, 32'h0,        18'd4, 16'h0,    16'h0,    32'hA5A55A5A);
        repeat (3) @(negedge clk);

        // Reset landing in the HIGH phase of a write.
        mon_en = 1'b0;
        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1036; write_data = 32'h11112222;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_high_addr", 32'(sram_addr), 32'd7);
        chk("pre_rst_high_we_n", 32'(sram_we_n), 32'd0);
        rst_n = 1'b0; wr_en = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_we_n", 32'(sram_we_n), 32'd1);
        chk("abort_oe_n", 32'(sram_oe_n), 32'd1);
        chk("abort_dq_z", 32'(sram_dq === 16'hzzzz), 32'd1);
        chk("abort_read_data", read_data, 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_stays_idle", {30'd0, ready, sram_we_n}, 32'd3);
        mon_en = 1'b1;

        access(1'b0, 1'b1, 32'd1024, 32'h0, 18'd0, 16'h0, 16'h0, 32'hDEADBEEF);
        repeat (3) @(negedge clk);
        chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
        chk("done_q_empty", 32'(done_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
